// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the 800x600 @ 72 Hz video link.
// Holds the default VESA timing constants, the per-axis phase type, the
// col/row widths and the record that travels down the display delay line.
// The transmit timing generator and the sync-decoding display controller
// both import this package so they agree on the timing.
package vga_pkg;

  // VESA 800x600 @ 72 Hz, 50 MHz pixel clock
  localparam int unsigned DEF_H_VISIBLE = 800;
  localparam int unsigned DEF_H_FRONT   = 56;
  localparam int unsigned DEF_H_SYNC    = 120;
  localparam int unsigned DEF_H_BACK    = 64;
  localparam int unsigned DEF_V_VISIBLE = 600;
  localparam int unsigned DEF_V_FRONT   = 37;
  localparam int unsigned DEF_V_SYNC    = 6;
  localparam int unsigned DEF_V_BACK    = 23;

  localparam int unsigned COL_W       = 12;
  localparam int unsigned ROW_W       = 11;
  localparam int unsigned MAX_H_TOTAL = 4096;
  localparam int unsigned MAX_V_TOTAL = 2048;

  typedef enum logic [1:0] {
    PH_VISIBLE = 2'd0,
    PH_FRONT   = 2'd1,
    PH_SYNC    = 2'd2,
    PH_BACK    = 2'd3
  } phase_t;

  // One display-side sample; delayed as a unit so every field stays aligned.
  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             visible;
    logic             line_start;
    logic             frame_start;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } disp_t;

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_VISIBLE: n = PH_FRONT;
      PH_FRONT:   n = PH_SYNC;
      PH_SYNC:    n = PH_BACK;
      default:    n = PH_VISIBLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical).
// A position counter plus a phase FSM VISIBLE -> FRONT -> SYNC -> BACK with a
// local count inside the current phase; a phase ends when its local count
// reaches its length minus 1.
// Ports:
//   clock   in  : rising-edge clock
//   reset   in  : synchronous, active-high; parks the axis on its last
//                 position (phase BACK) so the first advance lands on 0
//   advance in  : step the axis by one position this cycle
//   count   out : position within the axis, 0..TOTAL-1
//   phase   out : current phase (FSM state, also usable for debug)
//   wrap    out : combinational, high on the advance that returns count to 0
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned FRONT   = DEF_H_FRONT,
  parameter int unsigned SYNC    = DEF_H_SYNC,
  parameter int unsigned BACK    = DEF_H_BACK,
  parameter int unsigned W       = COL_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap
);

  localparam int unsigned TOTAL = VISIBLE + FRONT + SYNC + BACK;

  if (VISIBLE == 0 || FRONT == 0 || SYNC == 0 || BACK == 0) begin : g_bad_len
    $error("vga_axis_counter: every phase length must be at least 1");
  end
  if (TOTAL > (1 << W)) begin : g_bad_width
    $error("vga_axis_counter: axis total does not fit in the count width");
  end

  localparam logic [W-1:0] LAST_VISIBLE = W'(VISIBLE - 1);
  localparam logic [W-1:0] LAST_FRONT   = W'(FRONT - 1);
  localparam logic [W-1:0] LAST_SYNC    = W'(SYNC - 1);
  localparam logic [W-1:0] LAST_BACK    = W'(BACK - 1);
  localparam logic [W-1:0] LAST_TOTAL   = W'(TOTAL - 1);

  logic [W-1:0] local_count;
  logic [W-1:0] local_next;
  logic [W-1:0] count_next;
  logic [W-1:0] phase_last;
  logic         phase_end;
  phase_t       phase_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= LAST_TOTAL;
      local_count <= LAST_BACK;
      phase       <= PH_BACK;
    end else begin
      count       <= count_next;
      local_count <= local_next;
      phase       <= phase_next;
    end
  end

  always_comb begin
    phase_last = LAST_VISIBLE;
    case (phase)
      PH_VISIBLE: phase_last = LAST_VISIBLE;
      PH_FRONT:   phase_last = LAST_FRONT;
      PH_SYNC:    phase_last = LAST_SYNC;
      default:    phase_last = LAST_BACK;
    endcase

    phase_end = (local_count == phase_last);
    // The end of BACK is by construction the end of the whole axis, so the
    // position counter never needs its own terminal-count compare.
    wrap      = advance && (phase == PH_BACK) && phase_end;

    count_next = count;
    local_next = local_count;
    phase_next = phase;
    if (advance) begin
      count_next = wrap ? '0 : count + W'(1);
      if (phase_end) begin
        local_next = '0;
        phase_next = next_phase(phase);
      end else begin
        local_next = local_count + W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VESA 800x600 @ 72 Hz timing generator (transmit side).
// A lead counter pair (one vga_axis_counter per axis) runs PREFETCH cycles
// ahead of the monitor-side outputs. The lead position is offered to a
// framebuffer reader on req_*; the display outputs are the lead values
// delayed by exactly PREFETCH registers, and rgb_out is the returned pixel,
// registered on the same edge and blanked outside the visible area.
// Ports:
//   clock, reset              : pixel clock, synchronous active-high reset
//   hsync, vsync              : syncs, active level SYNC_POL
//   visible                   : display pixel lies in the active area
//   display_col, display_row  : display position
//   line_start, frame_start   : one-cycle pulses at col 0 / at (0,0)
//   req_valid, req_col, req_row : look-ahead pixel request
//   rgb_in                    : pixel data returned for the request
//   rgb_out                   : blanked pixel data to the DAC
//   h_phase, v_phase          : lead-axis phase states (debug)
//
// Request semantics: req_valid is a pure strobe with no ready; the position
// on req_col/req_row changes every clock and is meaningful only while
// req_valid=1. Data for a request presented after edge k must be on rgb_in
// before edge k+PREFETCH.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          SYNC_POL  = 1'b1,
  parameter int unsigned PREFETCH  = 2
) (
  input  logic             clock,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic [COL_W-1:0] display_col,
  output logic [ROW_W-1:0] display_row,
  output logic             line_start,
  output logic             frame_start,
  output logic             req_valid,
  output logic [COL_W-1:0] req_col,
  output logic [ROW_W-1:0] req_row,
  input  logic [23:0]      rgb_in,
  output logic [23:0]      rgb_out,
  output phase_t           h_phase,
  output phase_t           v_phase
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > MAX_H_TOTAL) begin : g_bad_h_total
    $error("vga_timing_gen: horizontal total exceeds 4096");
  end
  if (V_TOTAL > MAX_V_TOTAL) begin : g_bad_v_total
    $error("vga_timing_gen: vertical total exceeds 2048");
  end
  if (PREFETCH < 1 || PREFETCH > 4) begin : g_bad_prefetch
    $error("vga_timing_gen: PREFETCH must be in 1..4");
  end

  localparam disp_t IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, default: '0};

  // ---------------- lead counters ----------------
  logic [COL_W-1:0] h_count;
  logic [ROW_W-1:0] v_count;
  logic             h_wrap;
  logic             v_wrap;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .W       (COL_W)
  ) u_h_axis (
    .clock   (clock),
    .reset   (reset),
    .advance (1'b1),
    .count   (h_count),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .W       (ROW_W)
  ) u_v_axis (
    .clock   (clock),
    .reset   (reset),
    .advance (h_wrap),
    .count   (v_count),
    .phase   (v_phase),
    .wrap    (v_wrap)
  );

  // ---------------- lead record ----------------
  // The start pulses are the wrap strobes registered alongside the counters:
  // a wrap on this cycle means the lead sits on col 0 (row 0) next cycle.
  logic  lead_line_start;
  logic  lead_frame_start;
  logic  running;
  disp_t lead;

  always_comb begin
    lead             = IDLE;
    lead.hsync       = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    lead.vsync       = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    lead.visible     = (h_phase == PH_VISIBLE) && (v_phase == PH_VISIBLE);
    lead.line_start  = lead_line_start;
    lead.frame_start = lead_frame_start;
    lead.col         = h_count;
    lead.row         = v_count;
  end

  assign req_valid = lead.visible;
  assign req_col   = h_count;
  assign req_row   = v_count;

  // ---------------- display delay line ----------------
  // pipe_next[i] is what pipe_q[i] loads on the next edge. The parked reset
  // position of the lead is not a real pixel, so on the first edge after
  // reset (running=0) the line keeps loading the idle record instead; this
  // keeps the display outputs still until (0,0) arrives.
  disp_t pipe_next [PREFETCH];
  disp_t pipe_q    [PREFETCH];

  always_comb begin
    pipe_next[0] = running ? lead : IDLE;
    for (int i = 1; i < PREFETCH; i++) begin
      pipe_next[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      running          <= 1'b0;
      lead_line_start  <= 1'b0;
      lead_frame_start <= 1'b0;
      rgb_out          <= '0;
      for (int i = 0; i < PREFETCH; i++) begin
        pipe_q[i] <= IDLE;
      end
    end else begin
      running          <= 1'b1;
      lead_line_start  <= h_wrap;
      lead_frame_start <= v_wrap;
      // Blank on the visible flag being loaded into the output stage now,
      // so rgb_out and visible always change together.
      rgb_out          <= pipe_next[PREFETCH-1].visible ? rgb_in : '0;
      for (int i = 0; i < PREFETCH; i++) begin
        pipe_q[i] <= pipe_next[i];
      end
    end
  end

  assign hsync       = pipe_q[PREFETCH-1].hsync;
  assign vsync       = pipe_q[PREFETCH-1].vsync;
  assign visible     = pipe_q[PREFETCH-1].visible;
  assign display_col = pipe_q[PREFETCH-1].col;
  assign display_row = pipe_q[PREFETCH-1].row;
  assign line_start  = pipe_q[PREFETCH-1].line_start;
  assign frame_start = pipe_q[PREFETCH-1].frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen.
// Instance a: default 800x600@72 timing, SYNC_POL=1, PREFETCH=2.
// Instance b: shrunken timing (17x12), SYNC_POL=0, PREFETCH=4, so whole
// frames and a mid-vsync reset fit in a short run.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int NI = 2;
  localparam int HV[NI] = '{800, 10};
  localparam int HF[NI] = '{56, 2};
  localparam int HS[NI] = '{120, 3};
  localparam int HB[NI] = '{64, 2};
  localparam int VV[NI] = '{600, 5};
  localparam int VF[NI] = '{37, 2};
  localparam int VS[NI] = '{6, 2};
  localparam int VB[NI] = '{23, 3};
  localparam bit POL[NI] = '{1'b1, 1'b0};
  localparam int PF[NI] = '{2, 4};

  localparam int B_HT    = 17;
  localparam int B_VT    = 12;
  localparam int B_FRAME = B_HT * B_VT;
  localparam int N_STEPS = 3400;

  // ---------------- clock ----------------
  logic clock;
  initial clock = 1'b0;
  always #10 clock = ~clock;

  // ---------------- DUT a ----------------
  logic             reset_a;
  logic             hsync_a, vsync_a, visible_a, line_start_a, frame_start_a;
  logic [COL_W-1:0] display_col_a, req_col_a;
  logic [ROW_W-1:0] display_row_a, req_row_a;
  logic             req_valid_a;
  logic [23:0]      rgb_in_a, rgb_out_a;
  phase_t           h_phase_a, v_phase_a;

  vga_timing_gen u_dut_a (
    .clock       (clock),
    .reset       (reset_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .visible     (visible_a),
    .display_col (display_col_a),
    .display_row (display_row_a),
    .line_start  (line_start_a),
    .frame_start (frame_start_a),
    .req_valid   (req_valid_a),
    .req_col     (req_col_a),
    .req_row     (req_row_a),
    .rgb_in      (rgb_in_a),
    .rgb_out     (rgb_out_a),
    .h_phase     (h_phase_a),
    .v_phase     (v_phase_a)
  );

  // ---------------- DUT b ----------------
  logic             reset_b;
  logic             hsync_b, vsync_b, visible_b, line_start_b, frame_start_b;
  logic [COL_W-1:0] display_col_b, req_col_b;
  logic [ROW_W-1:0] display_row_b, req_row_b;
  logic             req_valid_b;
  logic [23:0]      rgb_in_b, rgb_out_b;
  phase_t           h_phase_b, v_phase_b;

  vga_timing_gen #(
    .H_VISIBLE (10), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_VISIBLE (5),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .SYNC_POL  (1'b0),
    .PREFETCH  (4)
  ) u_dut_b (
    .clock       (clock),
    .reset       (reset_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .visible     (visible_b),
    .display_col (display_col_b),
    .display_row (display_row_b),
    .line_start  (line_start_b),
    .frame_start (frame_start_b),
    .req_valid   (req_valid_b),
    .req_col     (req_col_b),
    .req_row     (req_row_b),
    .rgb_in      (rgb_in_b),
    .rgb_out     (rgb_out_b),
    .h_phase     (h_phase_b),
    .v_phase     (v_phase_b)
  );

  // ---------------- scoreboard state ----------------
  // word layout: [51] hsync [50] vsync [49] visible [48] line_start
  //              [47] frame_start [46:35] col [34:24] row [23:0] rgb
  logic [51:0] exp_q  [NI][$];
  logic [23:0] hist_q [NI][$];
  int          t_lead [NI];
  int          last_start [NI];
  int          sync_run [NI];
  int          vis_run [NI];
  logic [COL_W-1:0] prev_col_b;
  logic [ROW_W-1:0] prev_row_b;
  int          n_checks;
  int          n_pass;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_disp(input string pfx, input logic [51:0] got, input logic [51:0] exp);
    check_eq({pfx, "_hsync"},       32'(got[51]),    32'(exp[51]));
    check_eq({pfx, "_vsync"},       32'(got[50]),    32'(exp[50]));
    check_eq({pfx, "_visible"},     32'(got[49]),    32'(exp[49]));
    check_eq({pfx, "_line_start"},  32'(got[48]),    32'(exp[48]));
    check_eq({pfx, "_frame_start"}, 32'(got[47]),    32'(exp[47]));
    check_eq({pfx, "_col"},         32'(got[46:35]), 32'(exp[46:35]));
    check_eq({pfx, "_row"},         32'(got[34:24]), 32'(exp[34:24]));
    check_eq({pfx, "_rgb"},         32'(got[23:0]),  32'(exp[23:0]));
  endtask

  function automatic logic [51:0] idle_word(input int id);
    return {!POL[id], !POL[id], 3'b000, 12'd0, 11'd0, 24'd0};
  endfunction

  // Expected display record for linear frame position p; r is the random
  // tag the bench attaches to the pixel data it returns for that request.
  function automatic logic [51:0] model(input int id, input int p, input logic [11:0] r);
    int col, row, ht;
    bit vis, hs, vs;
    ht  = HV[id] + HF[id] + HS[id] + HB[id];
    col = p % ht;
    row = p / ht;
    vis = (col < HV[id]) && (row < VV[id]);
    hs  = (col >= HV[id] + HF[id] && col < HV[id] + HF[id] + HS[id]) ? POL[id] : !POL[id];
    vs  = (row >= VV[id] + VF[id] && row < VV[id] + VF[id] + VS[id]) ? POL[id] : !POL[id];
    return {hs, vs, vis, col == 0, col == 0 && row == 0, 12'(col), 11'(row),
            vis ? {r, 12'(col)} : 24'd0};
  endfunction

  // Score one instance after an edge; returns the rgb_in value to drive next.
  task automatic score(input int id, input bit rst_edge, input logic [51:0] obs,
                       input logic rv, input logic [COL_W-1:0] rc, input logic [ROW_W-1:0] rr,
                       output logic [23:0] drive);
    logic [51:0] w;
    logic [11:0] r;
    string       pfx;
    int          frame;
    pfx   = (id == 0) ? "a" : "b";
    frame = (HV[id] + HF[id] + HS[id] + HB[id]) * (VV[id] + VF[id] + VS[id] + VB[id]);
    r     = 12'($urandom_range(0, 4095));
    hist_q[id].push_back({r, rc});
    if (rst_edge) begin
      check_disp({pfx, "_rst"}, obs, idle_word(id));
      check_eq({pfx, "_rst_req_valid"}, 32'(rv), 32'd0);
      t_lead[id] = 0;
      exp_q[id].delete();
      repeat (PF[id]) exp_q[id].push_back(idle_word(id));
    end else begin
      t_lead[id]++;
      w = model(id, (t_lead[id] - 1) % frame, r);
      check_eq({pfx, "_req_valid"}, 32'(rv), 32'(w[49]));
      if (w[49]) begin
        check_eq({pfx, "_req_col"}, 32'(rc), 32'(w[46:35]));
        check_eq({pfx, "_req_row"}, 32'(rr), 32'(w[34:24]));
      end
      exp_q[id].push_back(w);
      check_disp(pfx, obs, exp_q[id].pop_front());
    end
    drive = '0;
    if (hist_q[id].size() == PF[id]) drive = hist_q[id].pop_front();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        ra, rb;
    logic [23:0] d;
    int          rst_b_left;
    bit          fired;
    n_checks = 0;
    n_pass   = 0;
    reset_a  = 1'b1;
    reset_b  = 1'b1;
    rgb_in_a = '0;
    rgb_in_b = '0;
    rst_b_left = 0;
    fired    = 1'b0;
    for (int i = 0; i < NI; i++) begin
      last_start[i] = -1; sync_run[i] = 0; vis_run[i] = 0; t_lead[i] = 0;
    end

    for (int step = 0; step < N_STEPS; step++) begin
      ra = reset_a;
      rb = reset_b;
      @(posedge clock);
      #1;

      // ---- instance a ----
      if (ra) begin
        check_eq("a_rst_h_phase", 32'(h_phase_a), 32'(PH_BACK));
        check_eq("a_rst_v_phase", 32'(v_phase_a), 32'(PH_BACK));
      end
      score(0, ra, {hsync_a, vsync_a, visible_a, line_start_a, frame_start_a,
                    display_col_a, display_row_a, rgb_out_a},
            req_valid_a, req_col_a, req_row_a, d);
      rgb_in_a = d;
      if (ra) begin
        last_start[0] = -1; sync_run[0] = 0; vis_run[0] = 0;
      end else begin
        if (line_start_a === 1'b1) begin
          if (last_start[0] >= 0) check_eq("a_line_period", 32'(step - last_start[0]), 32'd1040);
          last_start[0] = step;
        end
        if (hsync_a === 1'b1) sync_run[0]++;
        else begin
          if (sync_run[0] > 0) check_eq("a_hsync_width", 32'(sync_run[0]), 32'd120);
          sync_run[0] = 0;
        end
        if (visible_a === 1'b1) vis_run[0]++;
        else begin
          if (vis_run[0] > 0) check_eq("a_visible_width", 32'(vis_run[0]), 32'd800);
          vis_run[0] = 0;
        end
      end

      // ---- instance b ----
      if (rb) begin
        check_eq("b_rst_h_phase", 32'(h_phase_b), 32'(PH_BACK));
        check_eq("b_rst_v_phase", 32'(v_phase_b), 32'(PH_BACK));
      end
      score(1, rb, {hsync_b, vsync_b, visible_b, line_start_b, frame_start_b,
                    display_col_b, display_row_b, rgb_out_b},
            req_valid_b, req_col_b, req_row_b, d);
      rgb_in_b = d;
      if (rb) begin
        last_start[1] = -1; sync_run[1] = 0; vis_run[1] = 0;
      end else begin
        if (frame_start_b === 1'b1) begin
          if (last_start[1] >= 0) begin
            check_eq("b_frame_period", 32'(step - last_start[1]), 32'(B_FRAME));
            check_eq("b_wrap_col", 32'(prev_col_b), 32'(B_HT - 1));
            check_eq("b_wrap_row", 32'(prev_row_b), 32'(B_VT - 1));
          end
          last_start[1] = step;
        end
        if (vsync_b === 1'b0) sync_run[1]++;
        else begin
          if (sync_run[1] > 0) check_eq("b_vsync_width", 32'(sync_run[1]), 32'(2 * B_HT));
          sync_run[1] = 0;
        end
        if (visible_b === 1'b1) vis_run[1]++;
        else begin
          if (vis_run[1] > 0) check_eq("b_visible_width", 32'(vis_run[1]), 32'd10);
          vis_run[1] = 0;
        end
      end
      prev_col_b = display_col_b;
      prev_row_b = display_row_b;

      // Mid-vsync reset on b: lead at frame 2, row 7, col 5.
      if (!rb && !fired && (t_lead[1] - 1) == 2 * B_FRAME + 7 * B_HT + 5) begin
        check_eq("b_pre_rst_vsync", 32'(vsync_b), 32'd0);
        rst_b_left = 3;
        fired = 1'b1;
      end

      // ---- drive resets for the next edge ----
      reset_a = (step < 2);
      reset_b = (step < 2) || (rst_b_left > 0);
      if (rst_b_left > 0) rst_b_left--;
    end

    check_eq("b_reset_fired", 32'(fired), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
